// File: rtl/bcd16_to_bin12_pkg.sv
`default_nettype none
// ============================================================================
//  Package   : bcd_pkg
//  Purpose   : Shared widths, limits and state encoding for the BCD <-> binary
//              conversion blocks (this decoder and the binary-to-BCD encoder).
//  Revision  : 1.0  initial release
// ============================================================================
package bcd_pkg;

   localparam int BCD_DIGITS = 4;
   localparam int BCD_W      = 4 * BCD_DIGITS;
   localparam int BIN_W      = 12;
   localparam int ITER       = 16;
   localparam logic [BIN_W-1:0] MAX_BIN = 12'd4095;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      SHIFT = 2'd1,
      DONE  = 2'd2
   } state_t;

   // True when any packed nibble holds a non-decimal code (A..F).
   function automatic logic bcd_has_bad_digit(input logic [BCD_W-1:0] v);
      logic bad;
      bad = 1'b0;
      for (int i = 0; i < BCD_DIGITS; i++) begin
         if (v[4*i +: 4] > 4'd9) bad = 1'b1;
      end
      return bad;
   endfunction

endpackage
`default_nettype wire

// File: rtl/bcd16_to_bin12_if.sv
`default_nettype none
// ============================================================================
//  Interface : bcd16_to_bin12_if
//  Purpose   : Start/busy/done handshake plus operand and result bus of the
//              BCD-to-binary converter.
//  Revision  : 1.0  initial release
// ============================================================================
interface bcd16_to_bin12_if
   import bcd_pkg::*;
   ();

   logic             start;
   logic [BCD_W-1:0] bcd;
   logic             busy;
   logic             done;
   logic [BIN_W-1:0] out;
   logic             err_digit;
   logic             err_range;

   modport master (
      output start, bcd,
      input  busy, done, out, err_digit, err_range
   );

   modport slave (
      input  start, bcd,
      output busy, done, out, err_digit, err_range
   );

endinterface
`default_nettype wire

// File: rtl/bcd16_to_bin12_nibble_adjust.sv
`default_nettype none
// ============================================================================
//  Module    : bcd_nibble_adjust
//  Purpose   : Reverse double-dabble digit correction: after a right shift a
//              digit that picked up weight 8 from its upper neighbour really
//              carries weight 5, so values >= 8 are reduced by 3.
//  Revision  : 1.0  initial release
// ============================================================================
module bcd_nibble_adjust (
   input  logic [3:0] nib_i,
   output logic [3:0] nib_o
);

   // Subtract 3 from any digit that reached 8 or more after the shift.
   always_comb begin
      nib_o = (nib_i >= 4'd8) ? (nib_i - 4'd3) : nib_i;
   end

endmodule
`default_nettype wire

// File: rtl/bcd16_to_bin12.sv
`default_nettype none
// ============================================================================
//  Module    : bcd16_to_bin12
//  Purpose   : Sequential four-digit packed-BCD to 12-bit binary converter.
//              16 reverse double-dabble iterations, start/busy/done handshake,
//              invalid-digit and >4095 range flags (result saturates to FFF).
//  Revision  : 1.0  initial release
// ============================================================================
module bcd16_to_bin12
   import bcd_pkg::*;
(
   input  logic              clk,
   input  logic              reset_n,
   bcd16_to_bin12_if.slave   bus
);

   state_t           state_q, state_d;
   logic [3:0]       cnt_q, cnt_d;
   logic [BCD_W-1:0] sh_bcd_q, sh_bcd_d;
   logic [BCD_W-1:0] sh_bin_q, sh_bin_d;
   logic [BIN_W-1:0] out_q, out_d;
   logic             err_digit_q, err_digit_d;
   logic             err_range_q, err_range_d;

   // One iteration of the datapath: shift the pair right, then fix digits.
   logic [BCD_W-1:0] shr_bcd;
   logic [BCD_W-1:0] adj_bcd;
   logic [BCD_W-1:0] shr_bin;

   assign shr_bcd = {1'b0, sh_bcd_q[BCD_W-1:1]};
   assign shr_bin = {sh_bcd_q[0], sh_bin_q[BCD_W-1:1]};

   generate
      for (genvar g = 0; g < BCD_DIGITS; g++) begin : g_adj
         bcd_nibble_adjust u_adj (
            .nib_i (shr_bcd[4*g +: 4]),
            .nib_o (adj_bcd[4*g +: 4])
         );
      end
   endgenerate

   // State, counter, shift pair and result registers.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state_q     <= IDLE;
         cnt_q       <= 4'd0;
         sh_bcd_q    <= '0;
         sh_bin_q    <= '0;
         out_q       <= '0;
         err_digit_q <= 1'b0;
         err_range_q <= 1'b0;
      end else begin
         state_q     <= state_d;
         cnt_q       <= cnt_d;
         sh_bcd_q    <= sh_bcd_d;
         sh_bin_q    <= sh_bin_d;
         out_q       <= out_d;
         err_digit_q <= err_digit_d;
         err_range_q <= err_range_d;
      end
   end

   // Next-state logic: accept in IDLE, iterate in SHIFT, one-cycle DONE.
   always_comb begin
      state_d     = state_q;
      cnt_d       = cnt_q;
      sh_bcd_d    = sh_bcd_q;
      sh_bin_d    = sh_bin_q;
      out_d       = out_q;
      err_digit_d = err_digit_q;
      err_range_d = err_range_q;

      case (state_q)
         IDLE: begin
            if (bus.start) begin
               if (bcd_has_bad_digit(bus.bcd)) begin
                  // Bad digit: report immediately, skip the iterations.
                  state_d     = DONE;
                  out_d       = '0;
                  err_digit_d = 1'b1;
                  err_range_d = 1'b0;
               end else begin
                  state_d  = SHIFT;
                  sh_bcd_d = bus.bcd;
                  sh_bin_d = '0;
                  cnt_d    = 4'd0;
               end
            end
         end

         SHIFT: begin
            sh_bcd_d = adj_bcd;
            sh_bin_d = shr_bin;
            cnt_d    = cnt_q + 4'd1;
            if (cnt_q == 4'(ITER - 1)) begin
               // Result comes from this last iteration's shifted binary word.
               state_d     = DONE;
               err_digit_d = 1'b0;
               if (shr_bin > {{(BCD_W-BIN_W){1'b0}}, MAX_BIN}) begin
                  out_d       = MAX_BIN;
                  err_range_d = 1'b1;
               end else begin
                  out_d       = shr_bin[BIN_W-1:0];
                  err_range_d = 1'b0;
               end
            end
         end

         DONE: begin
            state_d = IDLE;
         end

         default: begin
            state_d = IDLE;
         end
      endcase
   end

   assign bus.busy      = (state_q != IDLE);
   assign bus.done      = (state_q == DONE);
   assign bus.out       = out_q;
   assign bus.err_digit = err_digit_q;
   assign bus.err_range = err_range_q;

endmodule
`default_nettype wire

// File: tb/tb_bcd16_to_bin12.sv
`default_nettype none
`timescale 1ns/1ps
// ============================================================================
//  Module    : tb_bcd16_to_bin12
//  Purpose   : Scoreboard bench for bcd16_to_bin12. Stimulus pushes the
//              decimal-model expectation (including the cycle done must show
//              up); a monitor pops and compares on every done pulse.
//  Revision  : 1.0  initial release
// ============================================================================
module tb_bcd16_to_bin12;

   logic clk = 1'b0;
   logic reset_n;

   bcd16_to_bin12_if bus ();

   bcd16_to_bin12 dut (
      .clk     (clk),
      .reset_n (reset_n),
      .bus     (bus)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic [15:0] bcd;
      logic [11:0] out;
      logic        ed;
      logic        er;
      int          due;
   } exp_t;

   exp_t sb[$];
   int   cyc      = 0;
   int   n_checks = 0;
   int   n_fail   = 0;
   bit   chk_idle = 1'b0;

   // Free-running cycle count; read on falling edges.
   always @(posedge clk) cyc <= cyc + 1;

   function automatic void check(input string name, input longint act, input longint req);
      n_checks++;
      if (act != req) begin
         n_fail++;
         $display("FAIL %s: got %0h required %0h (cycle %0d)", name, act, req, cyc);
      end
   endfunction

   // Decimal reference: digits weighted 1000/100/10/1, saturate above 4095.
   // acc is the cycle count of the accepting edge; done is visible right after
   // the accepting edge for a bad digit, 16 edges later otherwise.
   function automatic exp_t model(input logic [15:0] v, input int acc);
      exp_t e;
      int   dec;
      int   d;
      bit   bad;
      e.bcd = v;
      dec   = 0;
      bad   = 1'b0;
      for (int i = 3; i >= 0; i--) begin
         d = int'(v[4*i +: 4]);
         if (d > 9) bad = 1'b1;
         dec = dec * 10 + d;
      end
      if (bad) begin
         e.out = 12'h000; e.ed = 1'b1; e.er = 1'b0; e.due = acc;
      end else if (dec > 4095) begin
         e.out = 12'hFFF; e.ed = 1'b0; e.er = 1'b1; e.due = acc + 16;
      end else begin
         e.out = dec[11:0]; e.ed = 1'b0; e.er = 1'b0; e.due = acc + 16;
      end
      return e;
   endfunction

   function automatic logic [15:0] to_bcd(input int d);
      logic [15:0] r;
      r[15:12] = 4'((d / 1000) % 10);
      r[11:8]  = 4'((d / 100) % 10);
      r[7:4]   = 4'((d / 10) % 10);
      r[3:0]   = 4'(d % 10);
      return r;
   endfunction

   // Monitor: compare every done pulse against the oldest expectation.
   always @(negedge clk) begin
      exp_t e;
      if (reset_n) begin
         if (chk_idle) check("busy_after_done", bus.busy, 0);
         chk_idle = 1'b0;
         if (bus.done) begin
            chk_idle = 1'b1;
            if (sb.size() == 0) begin
               check("spurious_done", 1, 0);
            end else begin
               e = sb.pop_front();
               check("out", bus.out, e.out);
               check("err_digit", bus.err_digit, e.ed);
               check("err_range", bus.err_range, e.er);
               check("done_cycle", cyc, e.due);
            end
         end
      end else begin
         chk_idle = 1'b0;
      end
   end

   task automatic wait_idle();
      int g;
      g = 0;
      while (bus.busy !== 1'b0 && g < 64) begin
         @(negedge clk);
         g++;
      end
      if (g >= 64) check("idle_timeout", 1, 0);
   endtask

   task automatic drain();
      int g;
      g = 0;
      while (sb.size() != 0 && g < 64) begin
         @(negedge clk);
         g++;
      end
      if (g >= 64) check("drain_timeout", sb.size(), 0);
      @(negedge clk);
   endtask

   // Single-cycle start; the accepting edge is the next rising edge.
   task automatic issue(input logic [15:0] v, input bit expect_it);
      wait_idle();
      bus.start = 1'b1;
      bus.bcd   = v;
      if (expect_it) sb.push_back(model(v, cyc + 1));
      @(negedge clk);
      bus.start = 1'b0;
      check("busy_after_start", bus.busy, 1);
   endtask

   task automatic check_all_zero(input string tag);
      check({tag, "_busy"}, bus.busy, 0);
      check({tag, "_done"}, bus.done, 0);
      check({tag, "_out"}, bus.out, 0);
      check({tag, "_err_digit"}, bus.err_digit, 0);
      check({tag, "_err_range"}, bus.err_range, 0);
   endtask

   initial begin
      #500000;
      $display("FAIL watchdog: simulation did not finish (cycle %0d)", cyc);
      $fatal(1, "watchdog");
   end

   initial begin
      logic [15:0] directed [6];
      int c0;
      int r;

      reset_n   = 1'b0;
      bus.start = 1'b0;
      bus.bcd   = 16'h0000;
      repeat (3) @(negedge clk);
      check_all_zero("reset");
      reset_n = 1'b1;
      @(negedge clk);
      check_all_zero("post_reset");

      // Directed values including both sides of the 4095 boundary.
      directed = '{16'h0000, 16'h1234, 16'h4095, 16'h4096, 16'h9999, 16'h12A4};
      foreach (directed[i]) issue(directed[i], 1'b1);
      drain();

      // A start pulse while busy must neither queue nor resample bcd.
      issue(16'h0777, 1'b1);
      repeat (4) @(negedge clk);
      bus.start = 1'b1;
      bus.bcd   = 16'h0001;
      @(negedge clk);
      bus.start = 1'b0;
      bus.bcd   = 16'h0000;
      drain();
      wait_idle();

      // Reset in the middle of a conversion: outputs clear, no done follows.
      issue(16'h1234, 1'b0);
      repeat (7) @(negedge clk);
      reset_n = 1'b0;
      #1;
      check_all_zero("mid_reset");
      repeat (2) @(negedge clk);
      reset_n = 1'b1;
      repeat (20) @(negedge clk);
      check_all_zero("after_abort");

      // Start held high: IDLE->SHIFT(16)->DONE->IDLE, so a new accept every
      // 18 edges; three back-to-back conversions of 0042.
      wait_idle();
      bus.start = 1'b1;
      bus.bcd   = 16'h0042;
      c0 = cyc + 1;
      for (int k = 0; k < 3; k++) sb.push_back(model(16'h0042, c0 + 18 * k));
      repeat (37) @(negedge clk);
      bus.start = 1'b0;
      drain();

      // Randomised: legal decimals, raw 16-bit codes, values near 4095.
      for (int n = 0; n < 150; n++) begin
         r = int'($urandom_range(0, 3));
         case (r)
            0, 1:    issue(to_bcd(int'($urandom_range(0, 9999))), 1'b1);
            2:       issue(16'($urandom), 1'b1);
            default: issue(to_bcd(int'($urandom_range(4085, 4105))), 1'b1);
         endcase
         repeat ($urandom_range(0, 2)) @(negedge clk);
      end
      drain();
      check("scoreboard_empty", sb.size(), 0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
`default_nettype wire
